// File: rtl/mem_pkg.sv
// Shared definitions for the MEM/WB stage: funct3 encodings, FSM states,
// and the fault-decode and load-extension helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Unsigned sizes only make sense for loads; reserved encodings always fault.
    function automatic logic is_fault(input logic [2:0] funct3,
                                      input logic       is_store,
                                      input logic [1:0] addr_lo);
        logic f;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_BU:   f = is_store;
            F3_H:    f = addr_lo[0];
            F3_HU:   f = is_store | addr_lo[0];
            F3_W:    f = (addr_lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] r;
        shifted = word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    r = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   r = {24'h000000, shifted[7:0]};
            F3_H:    r = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   r = {16'h0000, shifted[15:0]};
            F3_W:    r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// Data memory: DEPTH_WORDS x 32 array, byte-enable synchronous write,
// combinational read. Contents are deliberately not reset.
module dmem_bytelane #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I memory-access stage with MEM/WB register: byte/half/word loads and
// stores, multi-cycle latency via upstream stall, misaligned/illegal fault flag.
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        reg_write_m,
    input  logic        mem_to_reg_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] rs2_data_m,
    input  logic [4:0]  rd_m,
    output logic        stall_mem,
    output logic        valid_w,
    output logic        reg_write_w,
    output logic        mem_to_reg_w,
    output logic [4:0]  rd_w,
    output logic [31:0] alu_result_w,
    output logic [31:0] load_data_w,
    output logic        mem_fault_w
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAST = 4'(MEM_LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        access, fault, good;
    logic        stall_raw;
    logic [3:0]  be_lanes;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    assign access = valid_m & (mem_read_m | mem_write_m);
    assign fault  = access & is_fault(funct3_m, mem_write_m, alu_result_m[1:0]);
    assign good   = access & ~fault;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (good && MEM_LATENCY > 1) begin
                    stall_raw  = 1'b1;
                    state_next = BUSY;
                    cnt_next   = 4'd1;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    stall_raw = 1'b1;
                    cnt_next  = cnt + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Gated by reset so an aborted access cannot re-raise the stall while
    // upstream still presents the same request.
    assign stall_mem = stall_raw & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        be_lanes  = 4'b1111;
        mem_wdata = rs2_data_m;
        case (funct3_m[1:0])
            2'b00: begin
                be_lanes  = 4'b0001 << alu_result_m[1:0];
                mem_wdata = {4{rs2_data_m[7:0]}};
            end
            2'b01: begin
                be_lanes  = alu_result_m[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{rs2_data_m[15:0]}};
            end
            default: begin
                be_lanes  = 4'b1111;
                mem_wdata = rs2_data_m;
            end
        endcase
    end

    // The store commits only on the edge leaving IDLE, never again in BUSY.
    assign mem_be = (state == IDLE && good && mem_write_m) ? be_lanes : '0;

    dmem_bytelane #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_dmem (
        .clk   (clk),
        .be    (mem_be),
        .addr  (alu_result_m[AW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            rd_w         <= '0;
            alu_result_w <= '0;
            load_data_w  <= '0;
            mem_fault_w  <= 1'b0;
        end else if (stall_mem) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            rd_w         <= '0;
            alu_result_w <= '0;
            load_data_w  <= '0;
            mem_fault_w  <= 1'b0;
        end else if (fault) begin
            valid_w      <= 1'b1;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= mem_to_reg_m;
            rd_w         <= rd_m;
            alu_result_w <= alu_result_m;
            load_data_w  <= '0;
            mem_fault_w  <= 1'b1;
        end else begin
            valid_w      <= valid_m;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            rd_w         <= rd_m;
            alu_result_w <= alu_result_m;
            load_data_w  <= (access && mem_read_m)
                            ? load_extend(funct3_m, alu_result_m[1:0], mem_rdata) : '0;
            mem_fault_w  <= 1'b0;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised memory-access stage plus MEM/WB pipeline register for the 5-stage RV32I core. It sits between EX/MEM and the write-back mux. It performs byte, halfword and word loads and stores with sign or zero extension. It supports a configurable multi-cycle data-memory latency by stalling upstream, and flags misaligned or illegal accesses instead of performing them.

## Interface
- DEPTH_WORDS, 1024: data memory size in 32-bit words; must be a power of two, at least 4.
- MEM_LATENCY, 1: cycles per memory access, legal range 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- valid_m  in  1  MEM-stage slot holds a real instruction.
- reg_write_m, mem_to_reg_m, mem_read_m, mem_write_m  in  1 each  control bits from EX/MEM.
- funct3_m  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result_m  in  32  effective address, or the ALU result.
- rs2_data_m  in  32  store data.
- rd_m  in  5  destination register.
- stall_mem  out  1  combinational; while high, upstream holds every *_m input stable.
- valid_w, reg_write_w, mem_to_reg_w  out  1 each  registered WB controls.
- rd_w  out  5  registered destination register.
- alu_result_w  out  32  registered ALU result.
- load_data_w  out  32  registered, extended load data.
- mem_fault_w  out  1  registered; misaligned or illegal access retired this cycle.

## Operation
- An access is `valid_m & (mem_read_m | mem_write_m)`. A fault is an access where any of these holds:
  - H/HU/SH with addr[0] ≠ 0;
  - W with addr[1:0] ≠ 0;
  - funct3 ∈ {011, 110, 111};
  - stores with funct3 ∈ {100, 101}.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so the index wraps.
- Stores: SB uses byte lane addr[1:0] and writes rs2[7:0]. SH uses lanes {addr[1],0},{addr[1],1} and writes rs2[15:0]. SW writes all four lanes. Unselected lanes are unchanged.
- Loads select the byte or halfword from the addressed lane. B/H sign-extend; BU/HU zero-extend.
- Faulting access:
  - no memory write and no stall;
  - retires next edge with valid_w=1, mem_fault_w=1, reg_write_w=0, load_data_w=0.
- Non-access instruction or bubble: all *_w outputs take the *_m values on the next edge; load_data_w=0, mem_fault_w=0.
- FSM states:
  - IDLE: on a non-faulting access with MEM_LATENCY=1, complete on the next edge and stay in IDLE. With MEM_LATENCY>1, go to BUSY with cnt=1.
  - BUSY: cnt increments each edge. When cnt==MEM_LATENCY-1, the next edge completes the access and returns to IDLE.
- Completion edge: capture load data read from the array at that edge; all *_w outputs take the *_m values.
- Store commit: the memory write happens exactly once, on the edge that leaves IDLE for the access. It is never repeated in BUSY.

## Timing
- stall_mem = (IDLE & non-faulting access & MEM_LATENCY>1) | (BUSY & cnt≠MEM_LATENCY-1).
- A memory access occupies MEM_LATENCY cycles, with stall_mem high for the first MEM_LATENCY-1 of them.
- On every edge where stall_mem=1, the W register loads a bubble: valid_w=0, reg_write_w=0, mem_to_reg_w=0, mem_fault_w=0. rd_w, alu_result_w and load_data_w are zeroed.
- Reset values: every output is 0, the FSM is IDLE and cnt=0. Memory contents are not reset; they are X until written.
- Reset mid-access aborts BUSY immediately and drops stall_mem to 0. A store already committed remains in memory.
- A store followed by a load to the same word returns the new data, because the store commits before the next access starts.

## Structure
- Package mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state enum {IDLE, BUSY};
  - the fault-decode and load-extend functions.
- Sub-module dmem_bytelane: DEPTH_WORDS x 32 array with a 4-bit byte-enable synchronous write port and a combinational read port. It has no reset.
- The top level contains the FSM, latency counter, fault decode, lane steering and W register.

## Test plan
- L=1: SW 0xDEADBEEF @0x10, then LB @0x13 → load_data_w=0xFFFFFFDE; LBU @0x13 → 0x000000DE; no stall.
- L=1: SH 0x1234 @0x22 over a word of 0xDEADBEEF, then LW @0x20 → 0x1234BEEF.
- L=3: LW asserts stall_mem for exactly 2 cycles with valid_w=0 bubbles; the third edge gives valid_w=1 with the correct data. An SW under the same latency writes once; a byte counter on the write enable reads 1.
- LH @0x21 → mem_fault_w=1, reg_write_w=0, memory unchanged, stall_mem=0; funct3=011 load → fault.
- L=4: assert reset in the second BUSY cycle → stall_mem=0 and all outputs 0 immediately; a previously committed SW is still readable after reset.
- DEPTH_WORDS=16: SW @0x40 then LW @0x00 → same data (index wrap); back-to-back ALU ops pass through with a 1-cycle latency.
